// File: rtl/f2_cpu_pkg.sv
// Shared types and default widths for the 68000 phase-enable / DTACKn controller.
package f2_cpu_pkg;

    localparam int unsigned CW_DEF = 4;
    localparam int unsigned WW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } phase_t;

endpackage

// File: rtl/f2_cen_phase_seq.sv
// Strict phi1/phi2 alternation of the incoming cen pulses, with optional phase injection
// on idle clocks; cpu_cen/cpu_cenb are registered (1 clk after the input pulse).
module f2_cen_phase_seq
    import f2_cpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cen_in,
    input  logic cenb_in,
    input  logic inject_ok,
    output logic cpu_cen,
    output logic cpu_cenb,
    output logic issue_cen,
    output logic inj_cenb
);

    phase_t phase;
    logic   inject;
    logic   issue_cenb;

    // Only the due phase can be issued, so dropped and injected pulses keep the alternation.
    always_comb begin
        inject     = inject_ok && !cen_in && !cenb_in;
        issue_cen  = (phase == P1) && (cen_in  || inject);
        issue_cenb = (phase == P2) && (cenb_in || inject);
        inj_cenb   = (phase == P2) && inject;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= P1;
            cpu_cen  <= 1'b0;
            cpu_cenb <= 1'b0;
        end else begin
            cpu_cen  <= issue_cen;
            cpu_cenb <= issue_cenb;
            if (issue_cen)
                phase <= P2;
            else if (issue_cenb)
                phase <= P1;
        end
    end

endmodule

// File: rtl/f2_cpu_dtack_ctrl.sv
// 68000 phase enables and DTACKn with programmed and SDRAM-busy wait states.
// Define F2_DTACK_RECOVERY_EN to re-issue phases lost while stalled on a busy SDRAM.
module f2_cpu_dtack_ctrl
    import f2_cpu_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned WW = WW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_in,
    input  logic          cenb_in,
    input  logic          cpu_as_n,
    input  logic [1:0]    cpu_ds_n,
    input  logic          bus_cs,
    input  logic          bus_busy,
    input  logic [WW-1:0] wait_cyc,
    output logic          cpu_cen,
    output logic          cpu_cenb,
    output logic          dtack_n,
    output logic [CW-1:0] lost_cnt
);

    localparam logic [CW-1:0] LOST_MAX = '1;

    state_t        state, state_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic [CW-1:0] lost_nx;
    logic          dtack_nx;
    logic          stall;
    logic          issue_cen;
    logic          inj_cenb;
    logic          inject_ok;

`ifdef F2_DTACK_RECOVERY_EN
    // Inhibited in WAIT so a stall increment never meets a recovery decrement.
    assign inject_ok = (state != WAIT) && (lost_cnt != '0);
`else
    assign inject_ok = 1'b0;
`endif

    f2_cen_phase_seq u_phase_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen_in    (cen_in),
        .cenb_in   (cenb_in),
        .inject_ok (inject_ok),
        .cpu_cen   (cpu_cen),
        .cpu_cenb  (cpu_cenb),
        .issue_cen (issue_cen),
        .inj_cenb  (inj_cenb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wcnt     <= '0;
            dtack_n  <= 1'b1;
            lost_cnt <= '0;
        end else begin
            state    <= state_nx;
            wcnt     <= wcnt_nx;
            dtack_n  <= dtack_nx;
            lost_cnt <= lost_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (issue_cen && !cpu_as_n && (cpu_ds_n != 2'b11)) begin
                    state_nx = WAIT;
                    wcnt_nx  = wait_cyc;
                end
            end
            WAIT: begin
                if (cpu_as_n)
                    state_nx = IDLE;
                else if (issue_cen) begin
                    if (wcnt != '0)
                        wcnt_nx = wcnt - 1'b1;
                    else if (bus_cs && bus_busy)
                        stall = 1'b1;
                    else
                        state_nx = ACK;
                end
            end
            ACK: begin
                if (cpu_as_n)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dtack_nx = (state_nx != ACK);
        lost_nx  = lost_cnt;
        if (stall && (lost_cnt != LOST_MAX))
            lost_nx = lost_cnt + 1'b1;
        else if (inj_cenb && (lost_cnt != '0))
            lost_nx = lost_cnt - 1'b1;
    end

endmodule

// File: tb/tb_f2_cpu_dtack_ctrl.sv
// Self-checking bench for f2_cpu_dtack_ctrl; covers the F2_DTACK_RECOVERY_EN build when defined.
module tb_f2_cpu_dtack_ctrl;

    localparam int CW = 4;
    localparam int WW = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          cen_in   = 1'b0;
    logic          cenb_in  = 1'b0;
    logic          cpu_as_n = 1'b1;
    logic [1:0]    cpu_ds_n = 2'b11;
    logic          bus_cs   = 1'b0;
    logic          bus_busy = 1'b0;
    logic [WW-1:0] wait_cyc = '0;
    logic          cpu_cen;
    logic          cpu_cenb;
    logic          dtack_n;
    logic [CW-1:0] lost_cnt;

    always #5 clk = ~clk;

    f2_cpu_dtack_ctrl #(.CW(CW), .WW(WW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen_in   (cen_in),
        .cenb_in  (cenb_in),
        .cpu_as_n (cpu_as_n),
        .cpu_ds_n (cpu_ds_n),
        .bus_cs   (bus_cs),
        .bus_busy (bus_busy),
        .wait_cyc (wait_cyc),
        .cpu_cen  (cpu_cen),
        .cpu_cenb (cpu_cenb),
        .dtack_n  (dtack_n),
        .lost_cnt (lost_cnt)
    );

    typedef struct packed {
        logic c;
        logic cb;
    } exp_t;

    typedef struct {
        bit c;
        bit cb;
        bit ec;
        bit ecb;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[10];
    int   errors = 0;
    int   checks = 0;
    bit   mdl_en = 1'b1;
    bit   m_phase = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cmp(input bit c, input bit cb, input bit ec, input bit ecb, input string name);
        exp_t e;
        e.c  = ec;
        e.cb = ecb;
        cen_in  = c;
        cenb_in = cb;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cen_in  = 1'b0;
        cenb_in = 1'b0;
        e = sbq.pop_front();
        chk({name, "_cen"},  cpu_cen,  e.c);
        chk({name, "_cenb"}, cpu_cenb, e.cb);
    endtask

    task automatic step(input bit c, input bit cb);
        bit ec, ecb;
        if (mdl_en) begin
            ec  = c  && !m_phase;
            ecb = cb &&  m_phase;
            if (ec || ecb)
                m_phase = !m_phase;
            drive_cmp(c, cb, ec, ecb, "phase");
        end else begin
            cen_in  = c;
            cenb_in = cb;
            @(posedge clk);
            #1;
            cen_in  = 1'b0;
            cenb_in = 1'b0;
        end
    endtask

    task automatic quad();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cen_in   = 1'b0;
        cenb_in  = 1'b0;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        bus_cs   = 1'b0;
        bus_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_phase = 1'b0;
        mdl_en  = 1'b1;
        sbq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_cen, n_cenb, consec, overlap;
        bit prev_cen;

        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0};
        tbl[2] = '{1, 0, 1, 0};
        tbl[3] = '{1, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 1};
        tbl[5] = '{1, 1, 1, 0};
        tbl[6] = '{0, 0, 0, 0};
        tbl[7] = '{0, 1, 0, 1};
        tbl[8] = '{0, 1, 0, 0};
        tbl[9] = '{1, 0, 1, 0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_cen",   cpu_cen,  0);
        chk("rst_cenb",  cpu_cenb, 0);
        chk("rst_dtack", dtack_n,  1);
        chk("rst_lost",  lost_cnt, 0);
        do_reset();

        // Alternation, dropped out-of-order and simultaneous pulses
        for (int i = 0; i < 10; i++)
            drive_cmp(tbl[i].c, tbl[i].cb, tbl[i].ec, tbl[i].ecb, $sformatf("tbl%0d", i));
        do_reset();

        repeat (6) quad();
        chk("steady_dtack", dtack_n, 1);

        // wait_cyc=2, no SDRAM
        wait_cyc = 2;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        quad();
        chk("B_entry_dtack", dtack_n, 1);
        quad();
        chk("B_w1_dtack", dtack_n, 1);
        quad();
        chk("B_w2_dtack", dtack_n, 1);
        step(1'b1, 1'b0);
        chk("B_ack_dtack", dtack_n, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("B_hold_dtack", dtack_n, 0);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(1'b0, 1'b0);
        chk("B_release_dtack", dtack_n, 1);
        do_reset();

        // SDRAM busy for 5 cpu_cen, releases on the same clk as the 6th
        wait_cyc = 0;
        bus_cs   = 1'b1;
        bus_busy = 1'b1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b01;
        quad();
        repeat (5) quad();
        chk("C_stall_dtack", dtack_n, 1);
        chk("C_stall_lost", lost_cnt, 5);
        bus_busy = 1'b0;
        step(1'b1, 1'b0);
        chk("C_ack_dtack", dtack_n, 0);
        chk("C_ack_lost", lost_cnt, 5);
        step(1'b0, 1'b1);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        bus_cs   = 1'b0;
`ifdef F2_DTACK_RECOVERY_EN
        mdl_en   = 1'b0;
        n_cen    = 0;
        n_cenb   = 0;
        consec   = 0;
        overlap  = 0;
        prev_cen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (cpu_cen)  n_cen++;
            if (cpu_cenb) n_cenb++;
            if (cpu_cen && prev_cen) consec++;
            if (cpu_cen && cpu_cenb) overlap++;
            prev_cen = cpu_cen;
        end
        chk("R_inj_cen",  n_cen,  5);
        chk("R_inj_cenb", n_cenb, 5);
        chk("R_consec",   consec, 0);
        chk("R_overlap",  overlap, 0);
        chk("R_lost",     lost_cnt, 0);
        chk("R_dtack",    dtack_n, 1);
`else
        n_cen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0);
            if (cpu_cen) n_cen++;
        end
        chk("C_no_inject", n_cen, 0);
        chk("C_hold_lost", lost_cnt, 5);
        chk("C_idle_dtack", dtack_n, 1);
`endif
        do_reset();

        // Saturation of lost_cnt, then abort from WAIT
        wait_cyc = 0;
        bus_cs   = 1'b1;
        bus_busy = 1'b1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b10;
        quad();
        repeat (15) quad();
        chk("D_lost15", lost_cnt, 15);
        repeat (5) quad();
        chk("D_sat_lost", lost_cnt, 15);
        chk("D_sat_dtack", dtack_n, 1);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        step(1'b1, 1'b0);
        chk("D_abort_dtack", dtack_n, 1);
`ifndef F2_DTACK_RECOVERY_EN
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        bus_cs   = 1'b0;
        bus_busy = 1'b0;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        quad();
        chk("D_reentry_dtack", dtack_n, 1);
        quad();
        chk("D_reack_dtack", dtack_n, 0);
        chk("D_reack_lost", lost_cnt, 15);
`endif
        do_reset();

        // Asynchronous reset in the middle of WAIT
        wait_cyc = 0;
        bus_cs   = 1'b1;
        bus_busy = 1'b1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        quad();
        step(1'b1, 1'b0);
        chk("E_pre_lost", lost_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("E_rst_cen",   cpu_cen,  0);
        chk("E_rst_cenb",  cpu_cenb, 0);
        chk("E_rst_dtack", dtack_n,  1);
        chk("E_rst_lost",  lost_cnt, 0);
        bus_cs   = 1'b0;
        bus_busy = 1'b0;
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_phase = 1'b0;
        mdl_en  = 1'b1;
        sbq.delete();
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        quad();
        chk("E_entry_dtack", dtack_n, 1);
        step(1'b1, 1'b0);
        chk("E_ack_dtack", dtack_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
